// File: rtl/seg7_pkg.sv
// Shared constants for the binary-to-BCD scanned 7-segment display: segment
// patterns (g..a, active-low), nibble width, FSM state type, digit-count helper.
package seg7_pkg;

  localparam int BCD_W = 4;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  // Decimal digits needed for 2^w-1, i.e. ceil(w*log10(2)) in fixed point.
  function automatic int min_digits(input int w);
    return (w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment pattern; non-decimal codes blank.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [BCD_W-1:0] i_nibble,
  output logic [6:0]       o_seg
);

  // NOTE: a default arm on every combinational case keeps the output fully
  // assigned on every path, so no latch is inferred.
  always_comb begin
    unique case (i_nibble)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bin2bcd_scan7seg.sv
// Sequential double-dabble binary-to-BCD converter with a multiplexed 7-segment scanner.
// Optional macro LEADING_ZERO_BLANK_EN blanks digits above the most-significant nonzero one.
module bin2bcd_scan7seg
  import seg7_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DIGITS   = 3,
  parameter int SCAN_DIV = 1000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  output logic [BCD_W*DIGITS-1:0]   bcd,
  output logic [6:0]                seg,
  output logic [DIGITS-1:0]         an
);

  localparam int BW    = BCD_W * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
    $error("bin2bcd_scan7seg: DIGITS too small for WIDTH");
  end

  state_t             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [BW-1:0]      r_bcd;
  logic [BW-1:0]      r_scratch;
  logic [WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]   r_cnt;
  logic [PRE_W-1:0]   r_pre;
  logic [IDX_W-1:0]   r_idx;
  logic [6:0]         r_seg;
  logic [DIGITS-1:0]  r_an;

  logic [BW-1:0]      w_adj;
  logic [BW-1:0]      w_bcd_next;
  logic [IDX_W-1:0]   w_idx_next;
  logic               w_pre_tc;
  logic [BCD_W-1:0]   w_nib;
  logic [6:0]         w_seg_dec;
  logic [6:0]         w_seg_next;

  always_comb begin
    w_adj = r_scratch;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_scratch[i*BCD_W +: BCD_W] >= 4'd5)
        w_adj[i*BCD_W +: BCD_W] = r_scratch[i*BCD_W +: BCD_W] + 4'd3;
    end
  end

  // NOTE: every register below uses non-blocking assignment so all state
  // updates see pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_bcd       <= '0;
      r_scratch   <= '0;
      r_shift     <= '0;
      r_cnt       <= '0;
    end else begin
      r_out_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_shift    <= in_data;
            r_scratch  <= '0;
            r_cnt      <= CNT_W'(WIDTH);
            r_in_ready <= 1'b0;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_scratch <= {w_adj[BW-2:0], r_shift[WIDTH-1]};
          r_shift   <= r_shift << 1;
          r_cnt     <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) r_state <= S_DONE;
        end
        S_DONE: begin
          r_bcd       <= r_scratch;
          r_out_valid <= 1'b1;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_in_ready <= 1'b1;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  // seg/an are registered from next-state values so they track r_idx and r_bcd
  // on the same edge.
  assign w_bcd_next = (r_state == S_DONE) ? r_scratch : r_bcd;
  assign w_pre_tc   = (r_pre == PRE_W'(SCAN_DIV - 1));
  assign w_idx_next = !w_pre_tc                    ? r_idx :
                      (r_idx == IDX_W'(DIGITS - 1)) ? '0    : r_idx + IDX_W'(1);
  assign w_nib      = w_bcd_next[int'(w_idx_next)*BCD_W +: BCD_W];

  seg7_decode u_decode (
    .i_nibble (w_nib),
    .o_seg    (w_seg_dec)
  );

`ifdef LEADING_ZERO_BLANK_EN
  assign w_seg_next = ((w_idx_next != '0) &&
                       ((w_bcd_next >> (BCD_W * int'(w_idx_next))) == '0))
                      ? SEG_BLANK : w_seg_dec;
`else
  assign w_seg_next = w_seg_dec;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
      r_seg <= SEG_0;
      r_an  <= ~DIGITS'(1);
    end else begin
      r_pre <= w_pre_tc ? '0 : r_pre + PRE_W'(1);
      r_idx <= w_idx_next;
      r_seg <= w_seg_next;
      r_an  <= ~(DIGITS'(1) << w_idx_next);
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign bcd       = r_bcd;
  assign seg       = r_seg;
  assign an        = r_an;

endmodule

// File: tb/tb_bin2bcd_scan7seg.sv
// Scoreboard bench for bin2bcd_scan7seg: driver pushes expected conversions,
// negedge monitor pops on out_valid and checks the scanned display every cycle.
module tb_bin2bcd_scan7seg;

  localparam int WIDTH    = 8;
  localparam int DIGITS   = 3;
  localparam int SCAN_DIV = 4;
  localparam int BW       = 4 * DIGITS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [WIDTH-1:0]  in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [BW-1:0]     bcd;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;

  bin2bcd_scan7seg #(.WIDTH(WIDTH), .DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .bcd       (bcd),
    .seg       (seg),
    .an        (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] bcd;
    int            val;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rel_cyc = 0;
  int   disp_val = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc++;

  function automatic logic [BW-1:0] to_bcd(input int unsigned v);
    logic [BW-1:0] r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_in_ready"},  64'(in_ready),  64'd1);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_bcd"},       64'(bcd),       64'd0);
    check({tag, "_an"},        64'(an),        64'(3'b110));
    check({tag, "_seg"},       64'(seg),       64'(7'b1000000));
  endtask

  // Monitor: scoreboard pop on out_valid, then display model comparison.
  exp_t              m_e;
  int                m_k, m_idx, m_dig;
  logic [DIGITS-1:0] m_an;
  logic [6:0]        m_seg;

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (out_valid) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_out_valid @cycle %0d: got bcd=%0h expected no pulse", cyc, bcd);
          end else begin
            m_e = q.pop_front();
            check("bcd", 64'(bcd), 64'(m_e.bcd));
            check("latency", 64'(cyc - m_e.acc), 64'(WIDTH + 1));
            disp_val = m_e.val;
          end
        end
        m_k   = cyc - rel_cyc;
        m_idx = (m_k / SCAN_DIV) % DIGITS;
        m_an  = '1;
        m_an[m_idx] = 1'b0;
        m_dig = (disp_val / pow10(m_idx)) % 10;
        m_seg = seg_of(m_dig);
`ifdef LEADING_ZERO_BLANK_EN
        if (m_idx > 0 && disp_val / pow10(m_idx) == 0) m_seg = 7'b1111111;
`endif
        check("an", 64'(an), 64'(m_an));
        check("seg", 64'(seg), 64'(m_seg));
      end
    end
  end

  task automatic send(input int unsigned v, input bit keep);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 100 cycles");
      return;
    end
    in_valid = 1'b1;
    in_data  = WIDTH'(v);
    q.push_back('{to_bcd(v), int'(v), cyc + 1});
    @(posedge clk);
    #1;
    check("in_ready_busy", 64'(in_ready), 64'd0);
    if (!keep) in_valid = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #1;
    rst_n   = 1'b1;
    rel_cyc = cyc;
    mon_en  = 1'b1;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", q.size());
    end
  endtask

  initial begin
    #23;
    check_reset("por");
    release_reset();
    repeat (3) @(negedge clk);
    check("no_pulse_after_reset", 64'(out_valid), 64'd0);

    send(255, 1'b0);
    send(0, 1'b0);
    send(100, 1'b0);
    send(137, 1'b0);
    drain();
    repeat (SCAN_DIV * DIGITS * 2) @(negedge clk);

    // Held in_valid: the value presented while busy is dropped, then accepted later.
    send(42, 1'b1);
    in_data = WIDTH'(99);
    send(99, 1'b0);
    drain();

    // Asynchronous reset in the middle of a conversion.
    send(200, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_reset("abort");
    q.delete();
    disp_val = 0;
    release_reset();
    repeat (WIDTH + 6) @(negedge clk);
    check("bcd_after_abort", 64'(bcd), 64'd0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send($urandom_range(0, (1 << WIDTH) - 1), 1'b0);
    end
    send((1 << WIDTH) - 1, 1'b0);
    drain();
    repeat (SCAN_DIV * DIGITS) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

endmodule
